// File: rtl/division_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Optional `DIVISION_DONE_EN adds a one-cycle done pulse that coincides with a fresh q/r.
module division_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy
`ifdef DIVISION_DONE_EN
    ,
    output logic             done
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // The partial remainder never reaches 2^WIDTH + divisor, so the top bit of the
    // WIDTH+1 bit difference is a clean borrow flag.
    always_comb begin
        w_shift   = {r_rem, r_dvd[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_dvs};
        w_ge      = ~w_diff[WIDTH];
        w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
`ifdef DIVISION_DONE_EN
            done    <= 1'b0;
`endif
        end else begin
`ifdef DIVISION_DONE_EN
            done <= 1'b0;
`endif
            // A start always wins, aborting any run in flight without touching q/r.
            if (start) begin
                r_dvd   <= a;
                r_dvs   <= b;
                r_rem   <= '0;
                r_quo   <= '0;
                r_cnt   <= '0;
                r_state <= S_RUN;
                busy    <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    q       <= w_quo_nxt;
                    r       <= w_rem_nxt;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
`ifdef DIVISION_DONE_EN
                    done    <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_division_seq.sv
// Directed self-checking bench for division_seq (WIDTH=32); covers done when DIVISION_DONE_EN is defined.
module tb_division_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
`ifdef DIVISION_DONE_EN
    logic        done;
`endif

    int n_pass  = 0;
    int n_total = 0;

    division_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy)
`ifdef DIVISION_DONE_EN
        ,
        .done  (done)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Starts a division, checks q/r hold and busy for 32 edges, then checks the result.
    task automatic run_div(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic [31:0] eq, input logic [31:0] er);
        logic [31:0] oq;
        logic [31:0] orr;
        bit          hold_ok;
        oq = q;
        orr = r;
        @(posedge clock); #1;
        start = 1'b1; a = ta; b = tb_v;
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        hold_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || q !== oq || r !== orr) hold_ok = 1'b0;
`ifdef DIVISION_DONE_EN
            if (done !== 1'b0) hold_ok = 1'b0;
`endif
            @(posedge clock); #1;
        end
        n_total++;
        if (hold_ok !== 1'b1) $display("FAIL %s_hold: got busy/q/r not held during run, expected held", nm);
        else n_pass++;
        n_total++;
        if (q !== eq) $display("FAIL %s_q: got %h expected %h", nm, q, eq);
        else n_pass++;
        n_total++;
        if (r !== er) $display("FAIL %s_r: got %h expected %h", nm, r, er);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_busy: got %b expected 0", nm, busy);
        else n_pass++;
`ifdef DIVISION_DONE_EN
        n_total++;
        if (done !== 1'b1) $display("FAIL %s_done: got %b expected 1", nm, done);
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL %s_done_once: got %b expected 0", nm, done);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        n_total++;
        if (q !== 32'd0) $display("FAIL reset_q: got %h expected 0", q);
        else n_pass++;
        n_total++;
        if (r !== 32'd0) $display("FAIL reset_r: got %h expected 0", r);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
`ifdef DIVISION_DONE_EN
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else n_pass++;
`endif
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_div("div_7_3", 32'd7, 32'd3, 32'd2, 32'd1);
    endtask

    task automatic test_vectors();
        run_div("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_3_7", 32'd3, 32'd7, 32'd0, 32'd3);
        run_div("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("div_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
    endtask

    task automatic test_div_zero();
        run_div("div_5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    endtask

    task automatic test_start_held();
        logic [31:0] oq;
        logic [31:0] orr;
        bit          hold_ok;
        oq = q;
        orr = r;
        hold_ok = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; a = 32'd7; b = 32'd3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b1 || q !== oq || r !== orr) hold_ok = 1'b0;
        end
        start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b1 || q !== oq || r !== orr) hold_ok = 1'b0;
        end
        n_total++;
        if (hold_ok !== 1'b1) $display("FAIL held_hold: got early completion, expected restart each cycle");
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (q !== 32'd2 || r !== 32'd1 || busy !== 1'b0)
            $display("FAIL held_result: got q=%h r=%h busy=%b expected q=2 r=1 busy=0", q, r, busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] oq;
        logic [31:0] orr;
        bit          hold_ok;
        oq = q;
        orr = r;
        @(posedge clock); #1;
        start = 1'b1; a = 32'd7; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        start = 1'b1; a = 32'd50; b = 32'd6;
        @(posedge clock); #1;
        start = 1'b0; a = 32'd1; b = 32'd1;
        hold_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || q !== oq || r !== orr) hold_ok = 1'b0;
`ifdef DIVISION_DONE_EN
            if (done !== 1'b0) hold_ok = 1'b0;
`endif
            @(posedge clock); #1;
        end
        n_total++;
        if (hold_ok !== 1'b1) $display("FAIL abort_hold: got result before restart completed, expected none");
        else n_pass++;
        n_total++;
        if (q !== 32'd8 || r !== 32'd2 || busy !== 1'b0)
            $display("FAIL abort_result: got q=%h r=%h busy=%b expected q=8 r=2 busy=0", q, r, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit quiet_ok;
        run_div("pre_reset_7_3", 32'd7, 32'd3, 32'd2, 32'd1);
        @(posedge clock); #1;
        start = 1'b1; a = 32'd9; b = 32'd2;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_total++;
        if (q !== 32'd0 || r !== 32'd0 || busy !== 1'b0)
            $display("FAIL reset_mid: got q=%h r=%h busy=%b expected all 0", q, r, busy);
        else n_pass++;
        #2;
        reset = 1'b0;
        quiet_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0) quiet_ok = 1'b0;
`ifdef DIVISION_DONE_EN
            if (done !== 1'b0) quiet_ok = 1'b0;
`endif
        end
        n_total++;
        if (quiet_ok !== 1'b1) $display("FAIL reset_mid_after: got activity after reset, expected idle zeros");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_start_held();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
